// File: rtl/text_render_if.sv
// Signal bundle between the text raster front end, the text RAM, the glyph ROM and the VGA pins.
// master = raster pipe side, slave = memories/pins side.
interface text_render_if;
  logic [11:0] text_addr;
  logic [7:0]  text_data;
  logic [7:0]  ascii;
  logic [2:0]  pix_x;
  logic [3:0]  pix_y;
  logic        bg_fg;
  logic        cursor_en;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic [11:0] rgb;
  logic        hsync;
  logic        vsync;
  logic        de;

  modport master (
    output text_addr, ascii, pix_x, pix_y, rgb, hsync, vsync, de,
    input  text_data, bg_fg, cursor_en, cursor_col, cursor_row
  );

  modport slave (
    input  text_addr, ascii, pix_x, pix_y, rgb, hsync, vsync, de,
    output text_data, bg_fg, cursor_en, cursor_col, cursor_row
  );
endinterface

// File: rtl/text_render_pipe.sv
// Text-mode VGA raster front end: beam counters, text-RAM addressing, glyph ROM drive
// and a 3-stage aligned RGB/sync/de output with a blinking block cursor.
module text_render_pipe #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter logic [11:0] FG_COLOR = 12'hFFF,
  parameter logic [11:0] BG_COLOR = 12'h00F
) (
  input  logic          clk,
  input  logic          resetn,
  text_render_if.master bus
);
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  logic [9:0] h_cnt_q, h_cnt_d;
  logic [9:0] v_cnt_q, v_cnt_d;
  logic [5:0] frame_cnt_q, frame_cnt_d;

  logic       act0, hs0, vs0, cur0;
  logic [6:0] col;
  logic [4:0] row;

  logic [2:0] pix_x_q;
  logic [3:0] pix_y_q;
  logic       act1_q, hs1_q, vs1_q, cur1_q;
  logic       act2_q, hs2_q, vs2_q, cur2_q;
  logic       de_q, hsync_q, vsync_q;
  logic [11:0] rgb_q, rgb_d;

  always_comb begin
    h_cnt_d     = h_cnt_q + 10'd1;
    v_cnt_d     = v_cnt_q;
    frame_cnt_d = frame_cnt_q;
    if (h_cnt_q == 10'(H_TOTAL - 1)) begin
      h_cnt_d = '0;
      if (v_cnt_q == 10'(V_TOTAL - 1)) begin
        v_cnt_d     = '0;
        frame_cnt_d = frame_cnt_q + 6'd1;
      end else begin
        v_cnt_d = v_cnt_q + 10'd1;
      end
    end
  end

  always_comb begin
    col  = h_cnt_q[9:3];
    row  = v_cnt_q[8:4];
    act0 = (h_cnt_q < 10'(H_ACTIVE)) && (v_cnt_q < 10'(V_ACTIVE));
    hs0  = !((h_cnt_q >= 10'(H_ACTIVE + H_FP)) &&
             (h_cnt_q <  10'(H_ACTIVE + H_FP + H_SYNC)));
    vs0  = !((v_cnt_q >= 10'(V_ACTIVE + V_FP)) &&
             (v_cnt_q <  10'(V_ACTIVE + V_FP + V_SYNC)));
    cur0 = bus.cursor_en && (col == bus.cursor_col) &&
           (row == bus.cursor_row) && frame_cnt_q[5];
  end

  // row*80 + col built from shifts: row*64 + row*16 + col
  assign bus.text_addr = {1'b0, row, 6'b0} + {3'b0, row, 4'b0} + {5'b0, col};
  assign bus.ascii     = bus.text_data;

  always_comb begin
    rgb_d = '0;
    if (act2_q) begin
      rgb_d = (bus.bg_fg ^ cur2_q) ? FG_COLOR : BG_COLOR;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      h_cnt_q     <= '0;
      v_cnt_q     <= '0;
      frame_cnt_q <= '0;
      pix_x_q     <= '0;
      pix_y_q     <= '0;
      act1_q      <= 1'b0;
      hs1_q       <= 1'b1;
      vs1_q       <= 1'b1;
      cur1_q      <= 1'b0;
      act2_q      <= 1'b0;
      hs2_q       <= 1'b1;
      vs2_q       <= 1'b1;
      cur2_q      <= 1'b0;
      de_q        <= 1'b0;
      hsync_q     <= 1'b1;
      vsync_q     <= 1'b1;
      rgb_q       <= '0;
    end else begin
      h_cnt_q     <= h_cnt_d;
      v_cnt_q     <= v_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      // stage 1: aligned with ascii returning from the text RAM
      pix_x_q     <= h_cnt_q[2:0];
      pix_y_q     <= v_cnt_q[3:0];
      act1_q      <= act0;
      hs1_q       <= hs0;
      vs1_q       <= vs0;
      cur1_q      <= cur0;
      // stage 2: aligned with bg_fg returning from the glyph ROM
      act2_q      <= act1_q;
      hs2_q       <= hs1_q;
      vs2_q       <= vs1_q;
      cur2_q      <= cur1_q;
      de_q        <= act2_q;
      hsync_q     <= hs2_q;
      vsync_q     <= vs2_q;
      rgb_q       <= rgb_d;
    end
  end

  assign bus.pix_x = pix_x_q;
  assign bus.pix_y = pix_y_q;
  assign bus.de    = de_q;
  assign bus.hsync = hsync_q;
  assign bus.vsync = vsync_q;
  assign bus.rgb   = rgb_q;
endmodule

// File: tb/tb_text_render_pipe.sv
// Bench for text_render_pipe: a full-size instance (timing, addressing, glyph path, mid-line reset)
// and a shrunk-timing instance (vsync and the 64-frame cursor blink) run side by side.
module tb_text_render_pipe;
  localparam int CLK_HALF = 20;
  localparam logic [11:0] FG = 12'hFFF;
  localparam logic [11:0] BG = 12'h00F;
  localparam int BHA = 16, BHF = 2, BHS = 4, BHB = 2;
  localparam int BVA = 32, BVF = 1, BVS = 2, BVB = 1;

  logic clk = 1'b0;
  logic rstn_a = 1'b0;
  logic rstn_b = 1'b0;
  int   ka = 0;
  int   kb = 0;
  int   errors = 0;
  int   checks = 0;

  always #CLK_HALF clk = ~clk;

  text_render_if ifa ();
  text_render_if ifb ();

  text_render_pipe dut_a (.clk(clk), .resetn(rstn_a), .bus(ifa.master));

  text_render_pipe #(
    .H_ACTIVE(BHA), .H_FP(BHF), .H_SYNC(BHS), .H_BP(BHB),
    .V_ACTIVE(BVA), .V_FP(BVF), .V_SYNC(BVS), .V_BP(BVB),
    .FG_COLOR(FG), .BG_COLOR(BG)
  ) dut_b (.clk(clk), .resetn(rstn_b), .bus(ifb.master));

  // Text RAM returns addr[7:0]; glyph ROM for A is pix_x[0], for B always background.
  always @(posedge clk) begin
    ifa.text_data <= ifa.text_addr[7:0];
    ifa.bg_fg     <= ifa.pix_x[0];
    ifb.text_data <= ifb.text_addr[7:0];
    ifb.bg_fg     <= 1'b0;
  end

  // Clock edges seen since reset release; after k edges the counters hold pixel k.
  always @(posedge clk or negedge rstn_a) begin
    if (!rstn_a) ka <= 0;
    else         ka <= ka + 1;
  end
  always @(posedge clk or negedge rstn_b) begin
    if (!rstn_b) kb <= 0;
    else         kb <= kb + 1;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (ka=%0d kb=%0d t=%0t)", name, got, exp, ka, kb, $time);
    end
  endtask

  // Pins after k edges show pixel k-3 of a raster with the given geometry.
  function automatic void model(
    input int k, input int ha, input int hf, input int hs, input int hb,
    input int va, input int vf, input int vs, input int vb,
    input bit glyph_odd, input bit gap_test, input int ccol, input int crow,
    output logic [11:0] rgb, output logic de, output logic hsn, output logic vsn);
    int p, x, line, y, f, ht, vt;
    bit hit, px, ce;
    rgb = '0; de = 1'b0; hsn = 1'b1; vsn = 1'b1;
    if (k < 3) return;
    ht   = ha + hf + hs + hb;
    vt   = va + vf + vs + vb;
    p    = k - 3;
    x    = p % ht;
    line = p / ht;
    y    = line % vt;
    f    = (line / vt) % 64;
    de   = (x < ha) && (y < va);
    hsn  = !((x >= ha + hf) && (x < ha + hf + hs));
    vsn  = !((y >= va + vf) && (y < va + vf + vs));
    ce   = !(gap_test && (f == 40 || f == 41));
    hit  = ce && ((x / 8) % 128 == ccol) && ((y / 16) % 32 == crow) && (f >= 32);
    px   = glyph_odd ? bit'(x % 2) : 1'b0;
    if (de) rgb = (px ^ hit) ? FG : BG;
  endfunction

  always @(negedge clk) begin
    logic [11:0] r;
    logic d, h, v;
    int x, y;
    model(ka, 640, 16, 96, 48, 480, 10, 2, 33, 1'b1, 1'b0, 5, 2, r, d, h, v);
    check("a_rgb", 32'(ifa.rgb), 32'(r));
    check("a_de", 32'(ifa.de), 32'(d));
    check("a_hsync", 32'(ifa.hsync), 32'(h));
    check("a_vsync", 32'(ifa.vsync), 32'(v));
    x = ka % 800; y = (ka / 800) % 525;
    if (x < 640 && y < 480) check("a_text_addr", 32'(ifa.text_addr), 32'((y / 16) * 80 + x / 8));
    if (ka >= 1) begin
      x = (ka - 1) % 800; y = ((ka - 1) / 800) % 525;
      check("a_pix_x", 32'(ifa.pix_x), 32'(x % 8));
      check("a_pix_y", 32'(ifa.pix_y), 32'(y % 16));
      if (x < 640 && y < 480) check("a_ascii", 32'(ifa.ascii), 32'(((y / 16) * 80 + x / 8) % 256));
    end else begin
      check("a_pix_x_rst", 32'(ifa.pix_x), 32'd0);
      check("a_pix_y_rst", 32'(ifa.pix_y), 32'd0);
    end

    model(kb, BHA, BHF, BHS, BHB, BVA, BVF, BVS, BVB, 1'b0, 1'b1, 1, 1, r, d, h, v);
    check("b_rgb", 32'(ifb.rgb), 32'(r));
    check("b_de", 32'(ifb.de), 32'(d));
    check("b_hsync", 32'(ifb.hsync), 32'(h));
    check("b_vsync", 32'(ifb.vsync), 32'(v));
    x = kb % 24; y = (kb / 24) % 36;
    if (x < BHA && y < BVA) check("b_text_addr", 32'(ifb.text_addr), 32'((y / 16) * 80 + x / 8));
  end

  task automatic wait_a(input int n);
    int g = 0;
    while (ka != n) begin
      @(negedge clk);
      g++;
      if (g > 100000) begin
        checks++; errors++;
        $display("FAIL wait_a: ka=%0d never reached %0d", ka, n);
        return;
      end
    end
  endtask

  task automatic wait_b(input int n);
    int g = 0;
    while (kb != n) begin
      @(negedge clk);
      g++;
      if (g > 100000) begin
        checks++; errors++;
        $display("FAIL wait_b: kb=%0d never reached %0d", kb, n);
        return;
      end
    end
  endtask

  task automatic seq_a();
    check("a_addr_origin", 32'(ifa.text_addr), 32'd0);
    wait_a(2);     check("a_de_before_first", 32'(ifa.de), 32'd0);
    wait_a(3);     check("a_de_first", 32'(ifa.de), 32'd1);
                   check("a_rgb_x0", 32'(ifa.rgb), 32'(BG));
    wait_a(4);     check("a_rgb_x1", 32'(ifa.rgb), 32'(FG));
    wait_a(642);   check("a_de_last", 32'(ifa.de), 32'd1);
    wait_a(643);   check("a_de_end", 32'(ifa.de), 32'd0);
                   check("a_rgb_blank", 32'(ifa.rgb), 32'd0);
    wait_a(658);   check("a_hs_pre", 32'(ifa.hsync), 32'd1);
    wait_a(659);   check("a_hs_fall", 32'(ifa.hsync), 32'd0);
    wait_a(754);   check("a_hs_low_end", 32'(ifa.hsync), 32'd0);
    wait_a(755);   check("a_hs_rise", 32'(ifa.hsync), 32'd1);
    wait_a(26443); check("a_cursor_off_even", 32'(ifa.rgb), 32'(BG));
    wait_a(26444); check("a_cursor_off_odd", 32'(ifa.rgb), 32'(FG));
    wait_a(28017); check("a_addr_17_35", 32'(ifa.text_addr), 32'd162);
    wait_a(28018); check("a_ascii_162", 32'(ifa.ascii), 32'd162);
                   check("a_pix_x_1", 32'(ifa.pix_x), 32'd1);
                   check("a_pix_y_3", 32'(ifa.pix_y), 32'd3);
    wait_a(29100);
    #5 rstn_a = 1'b0;
    #1;
    check("a_rst_rgb", 32'(ifa.rgb), 32'd0);
    check("a_rst_de", 32'(ifa.de), 32'd0);
    check("a_rst_hsync", 32'(ifa.hsync), 32'd1);
    check("a_rst_vsync", 32'(ifa.vsync), 32'd1);
    check("a_rst_pix_x", 32'(ifa.pix_x), 32'd0);
    repeat (3) @(negedge clk);
    rstn_a = 1'b1;
    wait_a(2);     check("a_re_de_before", 32'(ifa.de), 32'd0);
    wait_a(3);     check("a_re_de_first", 32'(ifa.de), 32'd1);
  endtask

  task automatic seq_b();
    wait_b(794);   check("b_vs_pre", 32'(ifb.vsync), 32'd1);
    wait_b(795);   check("b_vs_fall", 32'(ifb.vsync), 32'd0);
    wait_b(842);   check("b_vs_low_end", 32'(ifb.vsync), 32'd0);
    wait_b(843);   check("b_vs_rise", 32'(ifb.vsync), 32'd1);
    wait_b(27179); check("b_cursor_f31", 32'(ifb.rgb), 32'(BG));
    wait_b(28042); check("b_left_of_cursor_f32", 32'(ifb.rgb), 32'(BG));
    wait_b(28043); check("b_cursor_f32", 32'(ifb.rgb), 32'(FG));
    wait_b(34488); ifb.cursor_en = 1'b0;
    wait_b(34955); check("b_cursor_disabled_f40", 32'(ifb.rgb), 32'(BG));
    wait_b(36216); ifb.cursor_en = 1'b1;
    wait_b(36683); check("b_cursor_f42", 32'(ifb.rgb), 32'(FG));
    wait_b(54827); check("b_cursor_f63", 32'(ifb.rgb), 32'(FG));
    wait_b(55691); check("b_cursor_wrap_f0", 32'(ifb.rgb), 32'(BG));
    wait_b(55800);
  endtask

  initial begin
    ifa.cursor_en = 1'b1; ifa.cursor_col = 7'd5; ifa.cursor_row = 5'd2;
    ifb.cursor_en = 1'b1; ifb.cursor_col = 7'd1; ifb.cursor_row = 5'd1;
    rstn_a = 1'b0;
    rstn_b = 1'b0;
    repeat (3) @(negedge clk);
    rstn_a = 1'b1;
    rstn_b = 1'b1;
    fork
      seq_a();
      seq_b();
    join
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/text_render_pipe.md
# text_render_pipe

Text-mode raster front end of the debug screen. Generates 640x480 VGA timing, converts the beam position into a text-buffer address and glyph pixel coordinates, drives the glyph ROM (`ascii`, `pix_x`, `pix_y`), and consumes its registered `bg_fg` bit to produce aligned RGB, sync and data-enable outputs with an optional blinking block cursor. Sits between the text buffer RAM (upstream) and the glyph ROM plus the VGA pins (downstream).

## Interface
- `H_ACTIVE`, 640: visible pixels per line
- `H_FP` / `H_SYNC` / `H_BP`, 16 / 96 / 48: horizontal porch and sync widths
- `V_ACTIVE`, 480: visible lines
- `V_FP` / `V_SYNC` / `V_BP`, 10 / 2 / 33: vertical porch and sync widths
- `FG_COLOR`, 12'hFFF: foreground RGB444
- `BG_COLOR`, 12'h00F: background RGB444
- `clk` in 1: pixel clock (25 MHz); one clock domain
- `resetn` in 1: asynchronous, active-low reset
- `text_addr` out 12: text buffer address, row*80+col, 0..2399
- `text_data` in 8: ASCII code from the synchronous text RAM, valid 1 cycle after `text_addr`
- `ascii` out 8: glyph ROM character code (= `text_data`, pass-through)
- `pix_x` out 3: glyph column
- `pix_y` out 4: glyph row
- `bg_fg` in 1: glyph ROM pixel, valid 1 cycle after `ascii`/`pix_x`/`pix_y`
- `cursor_en` in 1: cursor display enable
- `cursor_col` in 7: cursor column 0..79
- `cursor_row` in 5: cursor row 0..29
- `rgb` out 12: pixel colour {R,G,B}, 4 bits each
- `hsync` out 1: horizontal sync, active low
- `vsync` out 1: vertical sync, active low
- `de` out 1: active-video enable

## Operation
- Stage 0 (counters): `h_cnt` 0..H_TOTAL-1 (H_TOTAL=800) increments every cycle. On wrap, `v_cnt` 0..V_TOTAL-1 (V_TOTAL=525) increments. On `v_cnt` wrap, a 6-bit `frame_cnt` increments and wraps 63->0.
- Stage 0 decode, combinational from the counters:
  - `act` = h_cnt<H_ACTIVE && v_cnt<V_ACTIVE
  - `hs_n` low for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC)
  - `vs_n` low for v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC)
- `col` = h_cnt[9:3], `row` = v_cnt[8:4].
- `text_addr` = (row<<6)+(row<<4)+col, combinational from stage-0 registers, no multiplier. Outside the active area the value is don't-care but stays in 12 bits.
- Stage 1 registers: `pix_x` <= h_cnt[2:0], `pix_y` <= v_cnt[3:0]. Sync, `act`, and `cur_hit` (cursor_en && col==cursor_col && row==cursor_row && frame_cnt[5]) are pipelined alongside.
- `ascii` = `text_data` (wire), so it is aligned with stage-1 `pix_x`/`pix_y`.
- Stage 2 registers: delayed sync, `act` and `cur_hit`, aligned with the returning `bg_fg`.
- Stage 3 output registers:
  - `de` <= act2; `hsync` <= hs2; `vsync` <= vs2
  - `rgb` <= !act2 ? 0 : ((bg_fg ^ cur_hit2) ? FG_COLOR : BG_COLOR)
- Cursor inputs are sampled in stage 0. A change takes effect on the next pixel.

## Timing
- Latency from counter state to pins is 3 cycles; all outputs share the same latency, so pixel (x,y) appears with the sync and `de` belonging to (x,y).
- `text_data` must arrive exactly 1 cycle after `text_addr`; `bg_fg` exactly 1 cycle after `ascii`.
- Reset (async assert, released synchronously by the system):
  - h_cnt, v_cnt, frame_cnt = 0
  - all pipeline `act`/`cur_hit` = 0, all pipeline syncs = 1
  - `rgb`=0, `de`=0, `hsync`=1, `vsync`=1, `pix_x`=0, `pix_y`=0
- The first `de`=1 is 3 cycles after the first clock edge with `resetn` high.
- Reset mid-frame: the pipeline flushes immediately. No partial sync pulse may be extended; outputs go to their reset values asynchronously.
- Frame period is 800*525 = 420000 cycles. The hsync low pulse is 96 cycles; the vsync low pulse is 2 lines (1600 cycles).
- Cursor blink: visible for frames with frame_cnt[5]=1, i.e. 32 frames on and 32 off.

## Test plan
- Reset release, count cycles: `de` first rises at cycle 3 and stays high 640 cycles. `hsync` first falls at cycle 656+3 and stays low 96 cycles. `vsync` low for 1600 cycles starting at line 490.
- Text RAM model returns `addr[7:0]`:
  - at h_cnt=17, v_cnt=35, `text_addr` = 2*80+2 = 162
  - the next cycle `ascii`=162, `pix_x`=1, `pix_y`=3
- Glyph model with `bg_fg` = `pix_x[0]`: active `rgb` alternates BG_COLOR/FG_COLOR. Blanking `rgb` = 0 regardless of `bg_fg`.
- Address corners: at (0,0) `text_addr`=0; at h_cnt=639, v_cnt=479 `text_addr`=2399.
- Cursor at col 5, row 2, `cursor_en`=1, `bg_fg` forced 0:
  - pixels x 40..47, y 32..47 output FG_COLOR only when frame_cnt>=32
  - 32-frame on/off period checked over 64 frames
  - `cursor_en`=0 gives no inversion
- Assert `resetn` low mid-line at h_cnt=300: `rgb`=0, `de`=0, `hsync`=`vsync`=1 at once. After release, timing restarts from (0,0) with latency 3.
